// File: rtl/div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2 -- multi-cycle radix-2 restoring divider for the E stage (DIV/DIVU)
//
// The hazard unit holds E stalled while a divide sits in E and ready is low.
// This block supplies that ready handshake and the {hi,lo} result that feeds
// the hilo register. An E-stage flush or exception arrives as annul and
// abandons whatever operation is in flight.
//
// Ports
//   clk         core clock, all state updates on the rising edge
//   resetn      asynchronous active-low reset
//   start       DIV/DIVU present in E and not yet done (held high while stalled)
//   signed_div  1 = DIV (two's complement operands), 0 = DIVU
//   annul       abandon the current operation, return to IDLE
//   dividend    rs value, sampled only when an operation is accepted
//   divisor     rt value, sampled only when an operation is accepted
//   result      {remainder (hi), quotient (lo)}, held until the next write
//   ready       one-cycle pulse: result valid, releases the divide stall
//
// Timing: start sampled in cycle 0 -> ready in cycle WIDTH+1. A zero divisor
// skips the iteration and reports ready in cycle 1 with result = 0.
// -----------------------------------------------------------------------------
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Magnitude of a value; only negative values in signed mode are negated.
    // The most negative value maps onto itself, which is exactly the
    // mod 2^WIDTH magnitude the unsigned core needs.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = (~v) + WIDTH'(1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Two's complement negation when requested (sign fixup of the result).
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic             neg);
        logic [WIDTH-1:0] n;
        if (neg) begin
            n = (~v) + WIDTH'(1);
        end else begin
            n = v;
        end
        return n;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   rem_r;        // partial remainder
    logic [WIDTH-1:0]   quo_r;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   dvs_r;        // divisor magnitude
    logic               neg_quo_r;    // quotient must be negated at the end
    logic               neg_rem_r;    // remainder must be negated at the end
    logic [2*WIDTH-1:0] result_r;
    logic               ready_r;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;
    logic               step_ok_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic               last_step_s;
    logic               div_zero_s;

    // One shift-subtract step. The remainder is always below the divisor, so
    // the shifted value is below twice the divisor and a WIDTH+1 bit trial
    // difference has its top bit set exactly when the subtraction underflows.
    always_comb begin
        shifted_s   = {rem_r, quo_r[WIDTH-1]};
        trial_s     = shifted_s - {1'b0, dvs_r};
        step_ok_s   = ~trial_s[WIDTH];
        if (step_ok_s) begin
            rem_next_s = trial_s[WIDTH-1:0];
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end
        quo_next_s  = {quo_r[WIDTH-2:0], step_ok_s};
        last_step_s = (cnt_r == LAST_STEP);
        div_zero_s  = (divisor == {WIDTH{1'b0}});
    end

    // Next-state logic; annul wins over everything, including start.
    always_comb begin
        state_next_s = state_r;
        if (annul) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (div_zero_s) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_BUSY;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (last_step_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                // The instruction that produced DONE is still in E with start
                // high, so DONE never restarts; it always drops back to IDLE.
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // ready is a flop that mirrors "state is DONE", so it pulses for exactly
    // the one cycle spent in DONE and never glitches on input changes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, iteration datapath and result write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            dvs_r     <= {WIDTH{1'b0}};
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
        end else if (annul) begin
            // Abandoned operation: leave result untouched.
            cnt_r <= cnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && div_zero_s) begin
                        result_r <= {(2*WIDTH){1'b0}};
                    end else if (start) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        rem_r     <= {WIDTH{1'b0}};
                        quo_r     <= magnitude(dividend, signed_div);
                        dvs_r     <= magnitude(divisor, signed_div);
                        neg_quo_r <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_r <= signed_div & dividend[WIDTH-1];
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_BUSY: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_step_s) begin
                        // Remainder follows the dividend's sign; quotient is
                        // negated when operand signs differ.
                        result_r <= {cond_negate(rem_next_s, neg_rem_r),
                                     cond_negate(quo_next_s, neg_quo_r)};
                    end else begin
                        result_r <= result_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign result = result_r;
    assign ready  = ready_r;

endmodule
